// File: rtl/sub_stage_pkg.sv
// sub_stage_pkg
// Shared definitions for the subtract issue stage: the FSM state encoding,
// the default operand width, the default settle time and the width of the
// settle counter (wide enough for any legal SETTLE_CYCLES, 1..255).
package sub_stage_pkg;

  localparam int unsigned WIDTH_DEFAULT         = 32;
  localparam int unsigned SETTLE_CYCLES_DEFAULT = 8;
  localparam int unsigned CNT_W                 = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/sub_flags.sv
// sub_flags
// Combinational result-flag generator for a subtraction op_a - op_b = diff.
// Ports:
//   op_a, op_b : operands as presented to the subtractor (WIDTH bits)
//   diff       : difference returned by the subtractor (WIDTH bits)
//   zero       : diff is all zeros
//   negative   : sign bit of diff
//   overflow   : signed overflow (operand signs differ and result sign
//                differs from the minuend)
//   borrow     : unsigned op_a < op_b
module sub_flags #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] diff,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             borrow
);

  // Flag equations evaluated from the operands and the returned difference.
  always_comb begin
    zero     = 1'b0;
    negative = 1'b0;
    overflow = 1'b0;
    borrow   = 1'b0;
    zero     = (diff == {WIDTH{1'b0}});
    negative = diff[WIDTH-1];
    overflow = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
    borrow   = (op_a < op_b);
  end

endmodule

// File: rtl/sub_issue_stage.sv
// sub_issue_stage
// Issues one operand pair at a time to an external combinational subtractor
// (instantiated by the parent), holds the operands stable for SETTLE_CYCLES
// clock edges, then captures the difference and its flags and presents them
// until the consumer accepts.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   in_valid / in_ready : operand handshake (a = minuend, b = subtrahend)
//   sub_a, sub_b        : registered operands driven to the subtractor
//   sub_diff            : difference returned by the subtractor
//   out_valid/out_ready : result handshake
//   diff                : captured difference
//   zero, negative, overflow, borrow : captured result flags
module sub_issue_stage
  import sub_stage_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
  parameter int unsigned WIDTH         = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  input  logic [WIDTH-1:0] sub_diff,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             borrow
);

  // Counter is loaded with SETTLE_CYCLES-1 so the capture lands exactly
  // SETTLE_CYCLES edges after the accepting edge.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sub_a_q;
  logic [WIDTH-1:0] sub_b_q;
  logic [WIDTH-1:0] diff_q;
  logic             zero_q;
  logic             negative_q;
  logic             overflow_q;
  logic             borrow_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             zero_s;
  logic             negative_s;
  logic             overflow_s;
  logic             borrow_s;

  // Flags are evaluated live on the held operands and the returned
  // difference; they are only registered at the capture edge.
  sub_flags #(
    .WIDTH (WIDTH)
  ) u_flags (
    .op_a     (sub_a_q),
    .op_b     (sub_b_q),
    .diff     (sub_diff),
    .zero     (zero_s),
    .negative (negative_s),
    .overflow (overflow_s),
    .borrow   (borrow_s)
  );

  // Issue FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sub_a_q     <= '0;
      sub_b_q     <= '0;
      diff_q      <= '0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
      borrow_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            sub_a_q    <= a;
            sub_b_q    <= b;
            cnt_q      <= CNT_LOAD;
            in_ready_q <= 1'b0;
            state_q    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            diff_q      <= sub_diff;
            zero_q      <= zero_s;
            negative_q  <= negative_s;
            overflow_q  <= overflow_s;
            borrow_q    <= borrow_s;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean idle.
          state_q     <= ST_IDLE;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sub_a     = sub_a_q;
  assign sub_b     = sub_b_q;
  assign diff      = diff_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign overflow  = overflow_q;
  assign borrow    = borrow_q;

endmodule

// File: doc/sub_issue_stage.md
SUB_ISSUE_STAGE -- requirements
Module: sub_issue_stage

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 8: clock edges the operands are held stable before the external subtractor output is sampled; legal range 1..255.
REQ-002 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operand pair offered.
REQ-006 SHALL have port in_ready, output, 1: stage can accept an operand pair.
REQ-007 SHALL have port a, input, WIDTH: minuend.
REQ-008 SHALL have port b, input, WIDTH: subtrahend.
REQ-009 SHALL have port sub_a, output, WIDTH: registered minuend driven to the external Sub32Bit.
REQ-010 SHALL have port sub_b, output, WIDTH: registered subtrahend driven to the external Sub32Bit.
REQ-011 SHALL have port sub_diff, input, WIDTH: combinational difference returned by Sub32Bit.
REQ-012 SHALL have port out_valid, output, 1: result and flags valid.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-014 SHALL have port diff, output, WIDTH: captured difference.
REQ-015 SHALL have ports zero, negative, overflow, borrow, output, 1 each: result flags.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, SETTLE, DONE.
REQ-017 IDLE: SHALL drive in_ready=1 and out_valid=0; on in_valid=1 at an edge, SHALL latch a/b into sub_a/sub_b, load the counter with SETTLE_CYCLES-1, and go to SETTLE.
REQ-018 SETTLE: SHALL drive in_ready=0 and hold sub_a/sub_b constant; SHALL decrement the counter each edge; at the edge where the counter is 0, SHALL capture sub_diff into diff, register the flags, and go to DONE.
REQ-019 Latency: capture SHALL occur exactly SETTLE_CYCLES edges after the accepting edge; out_valid SHALL be high from the next cycle on.
REQ-020 DONE: SHALL drive out_valid=1 and in_ready=0, holding diff and flags stable; on out_ready=1 at an edge, SHALL go to IDLE. There is no same-cycle re-accept, so throughput is one operation per SETTLE_CYCLES+2 cycles minimum.
REQ-021 in_valid while in_ready=0 SHALL be ignored; a and b SHALL NOT be sampled outside IDLE.
REQ-022 Flags SHALL be computed from the latched operands and the captured diff:
  - zero = (diff==0)
  - negative = diff[WIDTH-1]
  - overflow = (sub_a[MSB]!=sub_b[MSB]) && (diff[MSB]!=sub_a[MSB])
  - borrow = (sub_a < sub_b), unsigned
REQ-023 sub_a/sub_b SHALL retain their last values in DONE and IDLE until the next accept.
REQ-024 out_ready held high continuously SHALL result in exactly one DONE cycle per operation.

Reset
REQ-025 reset=1 at an edge SHALL force IDLE, clear the counter, and zero sub_a, sub_b, diff, and all flags; out_valid SHALL be 0 and in_ready SHALL be 1 the next cycle.
REQ-026 reset SHALL take priority over every handshake, including mid-SETTLE and mid-DONE; an in-flight operation SHALL be discarded with no out_valid.

Structure
REQ-027 The state enum, the WIDTH default, and the SETTLE_CYCLES default SHALL reside in shared package sub_stage_pkg.
REQ-028 Flag logic SHALL be a combinational sub-module sub_flags (inputs: operands, diff; outputs: four flags).
REQ-029 Sub32Bit SHALL be instantiated by the parent, not inside this block.

Verification
REQ-030 Accept a=8, b=9 -> diff=0xFFFFFFFF, negative=1, borrow=1, zero=0, overflow=0; out_valid rises exactly SETTLE_CYCLES+1 cycles after the accept.
REQ-031 Sequence (11,1), (11,15), (27,3), (11,1025) with out_ready=1 -> diff = 10, 0xFFFFFFFC, 24, 0xFFFFFC0A in order, with borrow = 0,1,0,1.
REQ-032 a=0x80000000, b=1 -> diff=0x7FFFFFFF, overflow=1; a=5, b=5 -> zero=1, all other flags 0.
REQ-033 out_ready held 0 for 20 cycles in DONE -> diff/flags stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-034 reset asserted on the 3rd SETTLE cycle -> next cycle IDLE, out_valid=0, outputs zero, no result emitted; a new op then completes normally.
REQ-035 SETTLE_CYCLES=1 build: out_valid is asserted 2 cycles after the accept, and sub_a/sub_b do not change during SETTLE.
